// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command decoder and its TX-side peers.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // ALU operands are staged through two fixed register-file slots
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_OPA,
    S_GET_OPB,
    S_GET_FUNC,
    S_ISSUE_WR,
    S_ISSUE_RD,
    S_ISSUE_A,
    S_ISSUE_B,
    S_ISSUE_ALU
  } state_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, expires at LIMIT-1.
// Clear has priority over enable, so a clear in the expiry cycle suppresses it.
module cmd_timeout_counter #(
  parameter int LIMIT = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CW'(LIMIT - 1));
  assign o_expire   = i_en && !i_clr && w_at_limit;

  // count enabled cycles; restart from zero on clear or on expiry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_expire) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Assembles UART byte frames into register-file and ALU requests.
//
// state        | meaning
// -------------+--------------------------------------------------
// S_IDLE       | waiting for an opcode byte
// S_GET_ADDR   | waiting for address byte (RF write / RF read)
// S_GET_DATA   | waiting for write-data byte
// S_GET_OPA    | waiting for ALU operand A
// S_GET_OPB    | waiting for ALU operand B
// S_GET_FUNC   | waiting for ALU function byte
// S_ISSUE_WR   | issuing RF write once downstream is free
// S_ISSUE_RD   | issuing RF read once downstream is free
// S_ISSUE_A    | writing operand A into its staging register
// S_ISSUE_B    | writing operand B into its staging register
// S_ISSUE_ALU  | issuing the ALU strobe
module uart_rx_cmd_decoder #(
  parameter int                 WIDTH          = 8,
  parameter int                 ADDR_WIDTH     = 4,
  parameter int                 FUNC_WIDTH     = 4,
  parameter int                 TIMEOUT_CYCLES = 4096,
  parameter logic [WIDTH-1:0]   CMD_RF_WR      = WIDTH'(uart_cmd_pkg::CMD_RF_WR),
  parameter logic [WIDTH-1:0]   CMD_RF_RD      = WIDTH'(uart_cmd_pkg::CMD_RF_RD),
  parameter logic [WIDTH-1:0]   CMD_ALU_OP     = WIDTH'(uart_cmd_pkg::CMD_ALU_OP),
  parameter logic [WIDTH-1:0]   CMD_ALU_NOP    = WIDTH'(uart_cmd_pkg::CMD_ALU_NOP)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_parity_error,
  input  logic                  i_stop_error,
  input  logic                  i_busy,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic [WIDTH-1:0]      o_rf_wr_data,
  output logic                  o_rf_wr_en,
  output logic                  o_rf_rd_en,
  output logic [FUNC_WIDTH-1:0] o_alu_func,
  output logic                  o_alu_en,
  output logic                  o_cmd_error,
  output logic                  o_overrun
);

  import uart_cmd_pkg::*;

  state_t                r_state;
  logic [WIDTH-1:0]      r_opcode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_opa;
  logic [WIDTH-1:0]      r_opb;
  logic [FUNC_WIDTH-1:0] r_func;

  logic w_in_get;
  logic w_in_issue;
  logic w_rx_bad;
  logic w_rx_ok;
  logic w_expire;

  assign w_in_get   = (r_state inside {S_GET_ADDR, S_GET_DATA, S_GET_OPA, S_GET_OPB, S_GET_FUNC});
  assign w_in_issue = (r_state inside {S_ISSUE_WR, S_ISSUE_RD, S_ISSUE_A, S_ISSUE_B, S_ISSUE_ALU});
  assign w_rx_bad   = i_rx_valid && (i_parity_error || i_stop_error);
  assign w_rx_ok    = i_rx_valid && !i_parity_error && !i_stop_error;

  // any arriving byte clears the timer, so a byte landing on the expiry cycle wins
  cmd_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (w_in_get),
    .i_clr    (i_rx_valid || !w_in_get),
    .o_expire (w_expire)
  );

  // frame assembly, request issue and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_opcode     <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_func       <= '0;
      o_rf_addr    <= '0;
      o_rf_wr_data <= '0;
      o_rf_wr_en   <= 1'b0;
      o_rf_rd_en   <= 1'b0;
      o_alu_func   <= '0;
      o_alu_en     <= 1'b0;
      o_cmd_error  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_rf_wr_en  <= 1'b0;
      o_rf_rd_en  <= 1'b0;
      o_alu_en    <= 1'b0;
      o_cmd_error <= 1'b0;
      o_overrun   <= 1'b0;

      if (w_in_get && (w_rx_bad || w_expire)) begin
        o_cmd_error <= 1'b1;
        r_state     <= S_IDLE;
      end else begin
        if (w_in_issue && i_rx_valid) begin
          o_overrun <= 1'b1;
        end

        case (r_state)
          S_IDLE: begin
            if (w_rx_bad) begin
              o_cmd_error <= 1'b1;
            end else if (w_rx_ok) begin
              r_opcode <= i_rx_data;
              if (i_rx_data == CMD_RF_WR || i_rx_data == CMD_RF_RD) begin
                r_state <= S_GET_ADDR;
              end else if (i_rx_data == CMD_ALU_OP) begin
                r_state <= S_GET_OPA;
              end else if (i_rx_data == CMD_ALU_NOP) begin
                r_state <= S_GET_FUNC;
              end else begin
                o_cmd_error <= 1'b1;
              end
            end
          end
          S_GET_ADDR: if (w_rx_ok) begin
            r_addr  <= i_rx_data[ADDR_WIDTH-1:0];
            r_state <= (r_opcode == CMD_RF_WR) ? S_GET_DATA : S_ISSUE_RD;
          end
          S_GET_DATA: if (w_rx_ok) begin
            r_data  <= i_rx_data;
            r_state <= S_ISSUE_WR;
          end
          S_GET_OPA: if (w_rx_ok) begin
            r_opa   <= i_rx_data;
            r_state <= S_GET_OPB;
          end
          S_GET_OPB: if (w_rx_ok) begin
            r_opb   <= i_rx_data;
            r_state <= S_GET_FUNC;
          end
          S_GET_FUNC: if (w_rx_ok) begin
            r_func  <= i_rx_data[FUNC_WIDTH-1:0];
            r_state <= (r_opcode == CMD_ALU_OP) ? S_ISSUE_A : S_ISSUE_ALU;
          end
          S_ISSUE_WR: if (!i_busy) begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= r_addr;
            o_rf_wr_data <= r_data;
            r_state      <= S_IDLE;
          end
          S_ISSUE_RD: if (!i_busy) begin
            o_rf_rd_en <= 1'b1;
            o_rf_addr  <= r_addr;
            r_state    <= S_IDLE;
          end
          S_ISSUE_A: if (!i_busy) begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= ADDR_WIDTH'(OPA_ADDR);
            o_rf_wr_data <= r_opa;
            r_state      <= S_ISSUE_B;
          end
          S_ISSUE_B: if (!i_busy) begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= ADDR_WIDTH'(OPB_ADDR);
            o_rf_wr_data <= r_opb;
            r_state      <= S_ISSUE_ALU;
          end
          S_ISSUE_ALU: if (!i_busy) begin
            o_alu_en   <= 1'b1;
            o_alu_func <= r_func;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Self-checking bench: frame-level reference model plus directed literal checks.
module tb_uart_rx_cmd_decoder;

  localparam int TMO = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       perr = 1'b0;
  logic       serr = 1'b0;
  logic       busy = 1'b0;

  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] alu_func;
  logic       alu_en;
  logic       cmd_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  uart_rx_cmd_decoder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .i_parity_error (perr),
    .i_stop_error   (serr),
    .i_busy         (busy),
    .o_rf_addr      (rf_addr),
    .o_rf_wr_data   (rf_wr_data),
    .o_rf_wr_en     (rf_wr_en),
    .o_rf_rd_en     (rf_rd_en),
    .o_alu_func     (alu_func),
    .o_alu_en       (alu_en),
    .o_cmd_error    (cmd_error),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: byte frames -> queue of requests ----------------
  typedef struct {
    bit         is_wr;
    bit         is_rd;
    bit         is_alu;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] func;
  } req_t;

  req_t       pend[$];
  logic [7:0] frame[$];
  int         idle_cnt = 0;

  logic [3:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [3:0] m_func = '0;
  logic       m_wr = 1'b0, m_rd = 1'b0, m_alu = 1'b0, m_err = 1'b0, m_ovr = 1'b0;

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic req_t mk(input bit w, input bit r, input bit a,
                              input logic [3:0] ad, input logic [7:0] d, input logic [3:0] f);
    req_t q;
    q.is_wr = w; q.is_rd = r; q.is_alu = a; q.addr = ad; q.data = d; q.func = f;
    return q;
  endfunction

  task automatic build_requests();
    logic [7:0] op, b1, b2, b3;
    op = frame[0];
    b1 = frame[1];
    b2 = (frame.size() > 2) ? frame[2] : 8'h00;
    b3 = (frame.size() > 3) ? frame[3] : 8'h00;
    case (op)
      8'hAA: pend.push_back(mk(1, 0, 0, b1[3:0], b2, 4'h0));
      8'hBB: pend.push_back(mk(0, 1, 0, b1[3:0], 8'h00, 4'h0));
      8'hCC: begin
        pend.push_back(mk(1, 0, 0, 4'd0, b1, 4'h0));
        pend.push_back(mk(1, 0, 0, 4'd1, b2, 4'h0));
        pend.push_back(mk(0, 0, 1, 4'h0, 8'h00, b3[3:0]));
      end
      default: pend.push_back(mk(0, 0, 1, 4'h0, 8'h00, b1[3:0]));
    endcase
  endtask

  task automatic model_step();
    req_t r;
    m_wr = 1'b0; m_rd = 1'b0; m_alu = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    if (!rst_n) begin
      pend.delete(); frame.delete(); idle_cnt = 0;
      m_addr = '0; m_data = '0; m_func = '0;
      return;
    end
    if (pend.size() != 0) begin
      if (rx_valid) m_ovr = 1'b1;
      if (!busy) begin
        r = pend.pop_front();
        if (r.is_wr) begin
          m_wr = 1'b1; m_addr = r.addr; m_data = r.data;
        end else if (r.is_rd) begin
          m_rd = 1'b1; m_addr = r.addr;
        end else begin
          m_alu = 1'b1; m_func = r.func;
        end
      end
    end else if (rx_valid) begin
      idle_cnt = 0;
      if (perr || serr) begin
        m_err = 1'b1; frame.delete();
      end else if (frame.size() == 0 && frame_len(rx_data) == 0) begin
        m_err = 1'b1;
      end else begin
        frame.push_back(rx_data);
        if (frame.size() == frame_len(frame[0])) begin
          build_requests();
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
      if (idle_cnt == TMO - 1) begin
        m_err = 1'b1; frame.delete(); idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("model.wr_en",      rf_wr_en,   m_wr);
    chk("model.rd_en",      rf_rd_en,   m_rd);
    chk("model.alu_en",     alu_en,     m_alu);
    chk("model.cmd_error",  cmd_error,  m_err);
    chk("model.overrun",    overrun,    m_ovr);
    chk("model.rf_addr",    rf_addr,    m_addr);
    chk("model.rf_wr_data", rf_wr_data, m_data);
    chk("model.alu_func",   alu_func,   m_func);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic pe, input logic se, input logic b);
    rx_valid = v; rx_data = d; perr = pe; serr = se; busy = b;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst.addr", rf_addr, 4'h0);
    chk("rst.data", rf_wr_data, 8'h00);
    chk("rst.wr_en", rf_wr_en, 1'b0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.addr", rf_addr, 4'h0);
    chk("reset.func", alu_func, 4'h0);
    chk("reset.err",  cmd_error, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // register write, back-to-back bytes
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr.en_early", rf_wr_en, 1'b0);
    idle(1);
    chk("wr.en", rf_wr_en, 1'b1);
    chk("wr.addr", rf_addr, 4'h5);
    chk("wr.data", rf_wr_data, 8'h3C);
    chk("wr.err", cmd_error, 1'b0);
    idle(1);
    chk("wr.single", rf_wr_en, 1'b0);

    // register read
    send(8'hBB); send(8'h0E); idle(1);
    chk("rd.en", rf_rd_en, 1'b1);
    chk("rd.addr", rf_addr, 4'hE);
    chk("rd.data_kept", rf_wr_data, 8'h3C);
    idle(1);
    chk("rd.single", rf_rd_en, 1'b0);

    // ALU with operands, held off by busy for 5 cycles
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("alu.busy_wr", rf_wr_en, 1'b0);
      chk("alu.busy_en", alu_en, 1'b0);
    end
    idle(1);
    chk("alu.wa_en", rf_wr_en, 1'b1);
    chk("alu.wa_addr", rf_addr, 4'h0);
    chk("alu.wa_data", rf_wr_data, 8'h12);
    idle(1);
    chk("alu.wb_en", rf_wr_en, 1'b1);
    chk("alu.wb_addr", rf_addr, 4'h1);
    chk("alu.wb_data", rf_wr_data, 8'h34);
    idle(1);
    chk("alu.en", alu_en, 1'b1);
    chk("alu.func", alu_func, 4'h1);
    chk("alu.wr_off", rf_wr_en, 1'b0);
    idle(1);

    // unknown opcode
    send(8'h7F);
    chk("unk.err", cmd_error, 1'b1);
    chk("unk.wr", rf_wr_en, 1'b0);
    idle(1);
    chk("unk.err_single", cmd_error, 1'b0);

    // parity error mid-frame, then recovery with DD,03
    send(8'hAA);
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk("par.err", cmd_error, 1'b1);
    send(8'hDD); send(8'h03); idle(1);
    chk("nop.en", alu_en, 1'b1);
    chk("nop.func", alu_func, 4'h3);

    // stop error in idle: byte not taken as opcode, so 03 is then unknown
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("stop.err", cmd_error, 1'b1);
    send(8'h03);
    chk("stop.next_unk", cmd_error, 1'b1);
    idle(1);

    // overrun during a busy ALU issue
    send(8'hDD); send(8'h05);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("ovr.pulse", overrun, 1'b1);
    chk("ovr.no_alu", alu_en, 1'b0);
    idle(1);
    chk("ovr.alu", alu_en, 1'b1);
    chk("ovr.func", alu_func, 4'h5);
    chk("ovr.single", overrun, 1'b0);

    // timeout: error after exactly TMO idle cycles
    send(8'hAA); send(8'h05);
    idle(TMO - 1);
    chk("tmo.not_yet", cmd_error, 1'b0);
    idle(1);
    chk("tmo.err", cmd_error, 1'b1);
    send(8'h3C);
    chk("tmo.idle_unk", cmd_error, 1'b1);
    idle(1);
    chk("tmo.no_wr", rf_wr_en, 1'b0);

    // byte arriving on the expiry cycle wins
    send(8'hAA); send(8'h07);
    idle(TMO - 1);
    send(8'h3C);
    chk("win.no_err", cmd_error, 1'b0);
    idle(1);
    chk("win.wr", rf_wr_en, 1'b1);
    chk("win.addr", rf_addr, 4'h7);

    // reset while an issue is stalled by busy: no strobe afterwards
    send(8'hAA); send(8'h09);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    idle(2);
    chk("rstiss.no_wr", rf_wr_en, 1'b0);

    // reset mid-frame: following 3C is treated as an unknown opcode
    send(8'hAA); send(8'h0A);
    pulse_reset();
    send(8'h3C);
    chk("rstfrm.err", cmd_error, 1'b1);
    idle(2);
    chk("rstfrm.no_wr", rf_wr_en, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Consumes the byte stream produced by the UART receiver: one-cycle valid pulse plus parity and stop error flags.
- Assembles multi-byte command frames and issues register-file write/read requests and ALU requests to the system controller datapath.
- Sits directly downstream of the UART receiver, in the receiver's clock domain.
- Handles framing errors, unknown opcodes, inter-byte timeout and downstream busy back-pressure.

Parameters:
- WIDTH, 8, data byte width.
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
- FUNC_WIDTH, 4, ALU function width; taken from the low bits of the function byte.
- TIMEOUT_CYCLES, 4096, idle cycles allowed between bytes of one frame before abort.
- CMD_RF_WR, 8'hAA, opcode: register write.
- CMD_RF_RD, 8'hBB, opcode: register read.
- CMD_ALU_OP, 8'hCC, opcode: ALU with operands.
- CMD_ALU_NOP, 8'hDD, opcode: ALU without operands.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  WIDTH  received byte
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- i_parity_error  in  1  parity error, qualified by i_rx_valid
- i_stop_error  in  1  stop error, qualified by i_rx_valid
- i_busy  in  1  downstream cannot accept a request this cycle
- o_rf_addr  out  ADDR_WIDTH  register address
- o_rf_wr_data  out  WIDTH  register write data
- o_rf_wr_en  out  1  one-cycle write strobe
- o_rf_rd_en  out  1  one-cycle read strobe
- o_alu_func  out  FUNC_WIDTH  ALU function
- o_alu_en  out  1  one-cycle ALU strobe
- o_cmd_error  out  1  one-cycle pulse: frame error, unknown opcode or timeout
- o_overrun  out  1  one-cycle pulse: byte dropped while issuing

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low (i_rst_n). All outputs, registers and the timeout counter clear to 0. FSM enters IDLE.
- All outputs are registered. A strobe asserts the cycle after its issue condition and lasts exactly one cycle.
- Accepted byte: i_rx_valid=1 with i_parity_error=0 and i_stop_error=0.
- Errored byte: i_rx_valid=1 with either error flag set.
  - In any collect state: aborts the frame, pulses o_cmd_error, returns to IDLE.
  - In IDLE: only pulses o_cmd_error.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, ISSUE_WR, ISSUE_RD, ISSUE_A, ISSUE_B, ISSUE_ALU.
- IDLE, on accepted byte:
  - AA or BB -> GET_ADDR (opcode latched).
  - CC -> GET_OPA.
  - DD -> GET_FUNC.
  - Any other value -> o_cmd_error pulse, stay IDLE.
- GET_ADDR: latch addr. AA -> GET_DATA; BB -> ISSUE_RD.
- GET_DATA: latch data -> ISSUE_WR.
- GET_OPA -> GET_OPB -> GET_FUNC, latching each byte.
- GET_FUNC: latch func -> ISSUE_ALU for DD, ISSUE_A for CC.
- ISSUE_WR: when !i_busy, o_rf_wr_en=1 with latched addr/data -> IDLE.
- ISSUE_RD: when !i_busy, o_rf_rd_en=1 -> IDLE.
- ISSUE_A: when !i_busy, write opA to addr 0 -> ISSUE_B.
- ISSUE_B: when !i_busy, write opB to addr 1 -> ISSUE_ALU.
- ISSUE_ALU: when !i_busy, o_alu_en=1 with o_alu_func -> IDLE.
- While i_busy=1, ISSUE_* states hold and outputs hold their values with strobes low.
- Any i_rx_valid during an ISSUE_* state: byte dropped, o_overrun pulses, state unaffected.
- Timeout:
  - Counter clears on every accepted byte and whenever in IDLE or ISSUE_*.
  - Counter increments every cycle in GET_* states.
  - Reaching TIMEOUT_CYCLES-1: abort to IDLE, o_cmd_error pulses.
  - Counter width is clog2(TIMEOUT_CYCLES).
  - If a valid byte and the timeout arrive in the same cycle, the byte wins and the counter clears.
- o_rf_addr/o_rf_wr_data retain the last issued values between requests.
- Reset mid-frame or mid-issue: immediate return to IDLE, no strobe emitted.

Decomposition:
- Package uart_cmd_pkg holds:
  - the opcode constants;
  - the FSM state enum;
  - ALU operand addresses (OPA_ADDR=0, OPB_ADDR=1).
- One sub-module, cmd_timeout_counter: enable, clear and expire pulse; reused by the TX-side frame logic.

Test Plan:
- AA,05,3C back-to-back, i_busy=0 -> one cycle after the 3C valid: o_rf_wr_en=1, o_rf_addr=5, o_rf_wr_data=3C; no error.
- BB,0E -> o_rf_rd_en=1, o_rf_addr=E, single-cycle pulse.
- CC,12,34,01 with i_busy=1 for 5 cycles after the func byte -> nothing until busy drops; then consecutive cycles carry:
  - wr addr0=12;
  - wr addr1=34;
  - o_alu_en with func=1.
- 7F in IDLE -> o_cmd_error pulse, no strobe.
- AA followed by a byte with i_parity_error=1 -> o_cmd_error pulse; a subsequent DD,03 yields o_alu_en, func=3.
- AA,05, then 4096 idle cycles -> o_cmd_error pulse, FSM IDLE. A byte sent during ISSUE_ALU with i_busy=1 -> o_overrun pulse.
